// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the SimpleRISC branch predictor:
// 2-bit counter encodings, the BTB entry layout and the sequential PC step.
package simplerisc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int PC_INC = 4;

    // Tag and target are carried at the widest supported PC width.
    // Each module narrows them to its own WIDTH.
    localparam int BTB_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
        ctr_t                 ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage. The fetch read port is combinational, so a
// same-cycle write to that index is seen only from the next cycle.
module btb_array
    import simplerisc_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int ENTRIES  = 16,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output btb_entry_t          rd_entry,
    input  logic [IDX_BITS-1:0] wr_idx,
    output btb_entry_t          wr_cur,
    input  logic                wr_en,
    input  btb_entry_t          wr_entry
);

    localparam int TAG_W = WIDTH - IDX_BITS - 2;

    logic             valid_mem  [ENTRIES];
    ctr_t             ctr_mem    [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [WIDTH-1:0] target_mem [ENTRIES];

    // Only valid and ctr need resetting; tag/target are ignored while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                ctr_mem[i]   <= SNT;
            end
        end else if (wr_en) begin
            valid_mem[wr_idx] <= wr_entry.valid;
            ctr_mem[wr_idx]   <= wr_entry.ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= TAG_W'(wr_entry.tag);
            target_mem[wr_idx] <= WIDTH'(wr_entry.target);
        end
    end

    always_comb begin
        rd_entry.valid  = valid_mem[rd_idx];
        rd_entry.tag    = BTB_MAX_W'(tag_mem[rd_idx]);
        rd_entry.target = BTB_MAX_W'(target_mem[rd_idx]);
        rd_entry.ctr    = ctr_mem[rd_idx];

        wr_cur.valid    = valid_mem[wr_idx];
        wr_cur.tag      = BTB_MAX_W'(tag_mem[wr_idx]);
        wr_cur.target   = BTB_MAX_W'(target_mem[wr_idx]);
        wr_cur.ctr      = ctr_mem[wr_idx];
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit with architectural E/GT flags, EX-stage branch resolution,
// BTB-based fetch prediction, mispredict redirect and saturating perf counters.
module branch_predict_unit
    import simplerisc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     fetch_pc,
    output logic                 pred_taken,
    output logic [WIDTH-1:0]     pred_target,
    input  logic                 ex_valid,
    input  logic [WIDTH-1:0]     ex_pc,
    input  logic                 is_cmp,
    input  logic                 is_beq,
    input  logic                 is_bgt,
    input  logic                 is_ubranch,
    input  logic                 is_ret,
    input  logic [WIDTH-1:0]     cmp_a,
    input  logic [WIDTH-1:0]     cmp_b,
    input  logic [WIDTH-1:0]     branch_target,
    input  logic [WIDTH-1:0]     op1,
    input  logic                 ex_pred_taken,
    input  logic [WIDTH-1:0]     ex_pred_target,
    output logic                 is_branch_taken,
    output logic [WIDTH-1:0]     branch_pc,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 flag_e,
    output logic                 flag_gt,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_W    = WIDTH - IDX_BITS - 2;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

    logic [IDX_BITS-1:0] fetch_idx, ex_idx;
    logic [TAG_W-1:0]    fetch_tag, ex_tag;
    btb_entry_t          rd_entry, wr_cur, wr_entry;
    logic                wr_en, fetch_hit, ex_hit, branch_class;

    // Shifting the whole PC keeps the unused byte-offset bits out of the slices.
    assign fetch_idx = IDX_BITS'(fetch_pc >> 2);
    assign fetch_tag = TAG_W'(fetch_pc >> (IDX_BITS + 2));
    assign ex_idx    = IDX_BITS'(ex_pc >> 2);
    assign ex_tag    = TAG_W'(ex_pc >> (IDX_BITS + 2));

    btb_array #(
        .WIDTH   (WIDTH),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (fetch_idx),
        .rd_entry (rd_entry),
        .wr_idx   (ex_idx),
        .wr_cur   (wr_cur),
        .wr_en    (wr_en),
        .wr_entry (wr_entry)
    );

    assign fetch_hit   = rd_entry.valid && (rd_entry.tag == BTB_MAX_W'(fetch_tag));
    assign pred_taken  = fetch_hit && rd_entry.ctr[1];
    assign pred_target = pred_taken ? WIDTH'(rd_entry.target) : '0;

    assign branch_class    = is_beq | is_bgt | is_ubranch | is_ret;
    assign is_branch_taken = ex_valid & ((is_beq & flag_e) | (is_bgt & flag_gt)
                                         | is_ubranch | is_ret);
    assign branch_pc       = is_ret ? op1 : branch_target;
    assign mispredict      = ex_valid & ((is_branch_taken != ex_pred_taken)
                             | (is_branch_taken & ex_pred_taken & (ex_pred_target != branch_pc)));
    assign redirect_pc     = is_branch_taken ? branch_pc : ex_pc + WIDTH'(PC_INC);

    assign ex_hit = wr_cur.valid && (wr_cur.tag == BTB_MAX_W'(ex_tag));

    // Hits train the counter; only taken misses allocate a fresh entry.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = wr_cur;
        if (ex_valid && branch_class) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (is_branch_taken) begin
                    wr_entry.ctr    = ctr_inc(wr_cur.ctr);
                    wr_entry.target = BTB_MAX_W'(branch_pc);
                end else begin
                    wr_entry.ctr    = ctr_dec(wr_cur.ctr);
                end
            end else if (is_branch_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = BTB_MAX_W'(ex_tag);
                wr_entry.target = BTB_MAX_W'(branch_pc);
                wr_entry.ctr    = WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_e  <= 1'b0;
            flag_gt <= 1'b0;
        end else if (ex_valid && is_cmp) begin
            flag_e  <= (cmp_a == cmp_b);
            flag_gt <= ($signed(cmp_a) > $signed(cmp_b));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid && branch_class && (branch_count != '1))
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; counters are narrowed to 4 bits
// so saturation is reachable in a short run.
module tb_branch_predict_unit;

    localparam int C_IDLE = 0, C_CMP = 1, C_BEQ = 2, C_BGT = 3, C_UB = 4, C_RET = 5, C_ALU = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc, ex_pc, cmp_a, cmp_b, branch_target, op1, ex_pred_target;
    logic        ex_valid, is_cmp, is_beq, is_bgt, is_ubranch, is_ret, ex_pred_taken;
    logic        pred_taken, is_branch_taken, mispredict, flag_e, flag_gt;
    logic [31:0] pred_target, branch_pc, redirect_pc;
    logic [3:0]  branch_count, mispredict_count;

    int tests  = 0;
    int errors = 0;

    branch_predict_unit #(
        .WIDTH       (32),
        .BTB_ENTRIES (16),
        .CNT_WIDTH   (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .is_cmp           (is_cmp),
        .is_beq           (is_beq),
        .is_bgt           (is_bgt),
        .is_ubranch       (is_ubranch),
        .is_ret           (is_ret),
        .cmp_a            (cmp_a),
        .cmp_b            (cmp_b),
        .branch_target    (branch_target),
        .op1              (op1),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .is_branch_taken  (is_branch_taken),
        .branch_pc        (branch_pc),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .flag_e           (flag_e),
        .flag_gt          (flag_gt),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one EX instruction, then let combinational outputs settle.
    task automatic applyStimulus(input int cls, input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] tgt,
                                 input logic [31:0] ra, input logic ptk,
                                 input logic [31:0] ptgt);
        ex_valid       = (cls != C_IDLE);
        is_cmp         = (cls == C_CMP);
        is_beq         = (cls == C_BEQ);
        is_bgt         = (cls == C_BGT);
        is_ubranch     = (cls == C_UB);
        is_ret         = (cls == C_RET);
        ex_pc          = pc;
        cmp_a          = a;
        cmp_b          = b;
        branch_target  = tgt;
        op1            = ra;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        #2;
    endtask

    task automatic checkCounts(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
        checkOutput({tag, "_branch_count"}, 32'(branch_count), exp_b);
        checkOutput({tag, "_mispredict_count"}, 32'(mispredict_count), exp_m);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation ran past its time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n    = 1'b0;
        fetch_pc = 32'h100;
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_pred_taken", 32'(pred_taken), 0);
        checkOutput("rst_pred_target", pred_target, 0);
        checkOutput("rst_flag_e", 32'(flag_e), 0);
        checkOutput("rst_flag_gt", 32'(flag_gt), 0);
        checkCounts("rst", 0, 0);
        #7 rst_n = 1'b1;
        tick();

        // cmp equal, then beq taken without prediction allocates the entry
        applyStimulus(C_CMP, 32'h80, 5, 5, 0, 0, 0, 0);
        tick();
        checkOutput("eq_flag_e", 32'(flag_e), 1);
        checkOutput("eq_flag_gt", 32'(flag_gt), 0);
        applyStimulus(C_BEQ, 32'h100, 0, 0, 32'h200, 0, 0, 0);
        checkOutput("beq_taken", 32'(is_branch_taken), 1);
        checkOutput("beq_mispredict", 32'(mispredict), 1);
        checkOutput("beq_redirect", redirect_pc, 32'h200);
        checkOutput("beq_same_cycle_pred", 32'(pred_taken), 0);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alloc_pred_taken", 32'(pred_taken), 1);
        checkOutput("alloc_pred_target", pred_target, 32'h200);
        checkCounts("alloc", 1, 1);

        // signed compare -1 vs 1, bgt not taken against a taken prediction
        applyStimulus(C_CMP, 32'h84, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        tick();
        checkOutput("neg_flag_gt", 32'(flag_gt), 0);
        checkOutput("neg_flag_e", 32'(flag_e), 0);
        applyStimulus(C_BGT, 32'h100, 0, 0, 32'h200, 0, 1, 32'h40);
        checkOutput("bgt_nt_taken", 32'(is_branch_taken), 0);
        checkOutput("bgt_nt_mispredict", 32'(mispredict), 1);
        checkOutput("bgt_nt_redirect", redirect_pc, 32'h104);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wnt_pred_taken", 32'(pred_taken), 0);
        checkOutput("wnt_pred_target", pred_target, 0);
        checkCounts("bgt_nt", 2, 2);

        // 3 > -2 signed sets GT; four taken hits saturate the counter
        applyStimulus(C_CMP, 32'h88, 3, 32'hFFFF_FFFE, 0, 0, 0, 0);
        tick();
        checkOutput("pos_flag_gt", 32'(flag_gt), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(C_UB, 32'h100, 0, 0, 32'h200, 0, 1, 32'h200);
            checkOutput("ub_hit_mispredict", 32'(mispredict), 0);
            tick();
        end
        applyStimulus(C_BGT, 32'h100, 0, 0, 32'h200, 0, 1, 32'h200);
        checkOutput("bgt_t_taken", 32'(is_branch_taken), 1);
        checkOutput("bgt_t_mispredict", 32'(mispredict), 0);
        tick();
        applyStimulus(C_BEQ, 32'h100, 0, 0, 32'h200, 0, 1, 32'h200);
        checkOutput("beq_nt_taken", 32'(is_branch_taken), 0);
        checkOutput("beq_nt_redirect", redirect_pc, 32'h104);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_dec_pred_taken", 32'(pred_taken), 1);
        checkOutput("sat_dec_pred_target", pred_target, 32'h200);
        applyStimulus(C_BEQ, 32'h100, 0, 0, 32'h200, 0, 1, 32'h200);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("second_dec_pred_taken", 32'(pred_taken), 0);
        checkCounts("sat", 8, 4);

        // ret with a wrong predicted target retrains the entry
        applyStimulus(C_RET, 32'h100, 0, 0, 32'h1234, 32'h3000, 1, 32'h2000);
        checkOutput("ret_branch_pc", branch_pc, 32'h3000);
        checkOutput("ret_mispredict", 32'(mispredict), 1);
        checkOutput("ret_redirect", redirect_pc, 32'h3000);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ret_pred_taken", 32'(pred_taken), 1);
        checkOutput("ret_pred_target", pred_target, 32'h3000);

        // 0x10 and 0x50 share index 4
        applyStimulus(C_UB, 32'h10, 0, 0, 32'h400, 0, 0, 0);
        tick();
        fetch_pc = 32'h10;
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alias_first_pred", 32'(pred_taken), 1);
        checkOutput("alias_first_target", pred_target, 32'h400);
        applyStimulus(C_UB, 32'h50, 0, 0, 32'h500, 0, 1, 32'h400);
        checkOutput("alias_same_cycle_pred", 32'(pred_taken), 1);
        checkOutput("alias_same_cycle_target", pred_target, 32'h400);
        checkOutput("alias_target_mispredict", 32'(mispredict), 1);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alias_evicted_pred", 32'(pred_taken), 0);
        checkOutput("alias_evicted_target", pred_target, 0);
        fetch_pc = 32'h50;
        #1;
        checkOutput("alias_new_target", pred_target, 32'h500);

        // non-branch predicted taken through aliasing must not touch the BTB
        applyStimulus(C_ALU, 32'h10, 0, 0, 0, 0, 1, 32'h500);
        checkOutput("alu_mispredict", 32'(mispredict), 1);
        checkOutput("alu_redirect", redirect_pc, 32'h14);
        tick();
        applyStimulus(C_ALU, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'h500);
        checkOutput("wrap_redirect", redirect_pc, 32'h0);
        tick();
        applyStimulus(C_IDLE, 32'h10, 0, 0, 32'h700, 0, 1, 32'h500);
        is_ubranch = 1'b1;
        #1;
        checkOutput("novalid_taken", 32'(is_branch_taken), 0);
        checkOutput("novalid_mispredict", 32'(mispredict), 0);
        tick();
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alias_kept_target", pred_target, 32'h500);
        checkCounts("alias", 11, 9);

        // drive both 4-bit counters past all-ones
        for (int i = 0; i < 6; i++) begin
            applyStimulus(C_UB, 32'h200, 0, 0, 32'h600, 0, 1, 32'h600);
            tick();
        end
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkCounts("bsat", 15, 9);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(C_ALU, 32'h204, 0, 0, 0, 0, 1, 32'h600);
            tick();
        end
        applyStimulus(C_IDLE, 0, 0, 0, 0, 0, 0, 0);
        checkCounts("msat", 15, 15);

        // asynchronous reset in mid-cycle clears outputs at once
        fetch_pc = 32'h200;
        #1;
        checkOutput("pre_reset_pred", 32'(pred_taken), 1);
        checkOutput("pre_reset_target", pred_target, 32'h600);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pred_taken", 32'(pred_taken), 0);
        checkOutput("midrst_pred_target", pred_target, 0);
        checkOutput("midrst_flag_gt", 32'(flag_gt), 0);
        checkCounts("midrst", 0, 0);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("post_reset_pred", 32'(pred_taken), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
